// File: rtl/alarma_ctrl_temporizada.sv
// Timed car-alarm controller: arms with ignition off, waits a grace delay on
// the lights-on/door-open condition, then drives a timed blinking siren.
module alarma_ctrl_temporizada #(
  parameter int DELAY     = 8,
  parameter int ALARM_LEN = 64,
  parameter int BLINK     = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sLuz,
  input  logic       sPrta,
  input  logic       sIgn,
  output logic       sAlr,
  output logic       sParp,
  output logic [1:0] estado,
  output logic [3:0] nEventos
);

  localparam int BLK_W = (BLINK > 1) ? $clog2(BLINK) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_PRE   = 2'b10,
    S_ALARM = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_tmr;
  logic [CNT_W-1:0]   w_tmr_nxt;
  logic [BLK_W-1:0]   r_blk;
  logic [BLK_W-1:0]   w_blk_nxt;
  logic               r_alr;
  logic               w_alr_nxt;
  logic               r_parp;
  logic               w_parp_nxt;
  logic [3:0]         r_nev;
  logic [3:0]         w_nev_nxt;
  logic               w_cond;
  logic               w_tmr_zero;

  assign w_cond     = sLuz & sPrta & ~sIgn;
  assign w_tmr_zero = (r_tmr == {CNT_W{1'b0}});

  // State, timers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tmr   <= {CNT_W{1'b0}};
      r_blk   <= {BLK_W{1'b0}};
      r_alr   <= 1'b0;
      r_parp  <= 1'b0;
      r_nev   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_blk   <= w_blk_nxt;
      r_alr   <= w_alr_nxt;
      r_parp  <= w_parp_nxt;
      r_nev   <= w_nev_nxt;
    end
  end

  // Next-state decision; ignition on always forces IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (sIgn) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_ARMED;
        S_ARMED: w_state_nxt = w_cond ? S_PRE : S_ARMED;
        S_PRE: begin
          if (!w_cond)         w_state_nxt = S_ARMED;
          else if (w_tmr_zero) w_state_nxt = S_ALARM;
          else                 w_state_nxt = S_PRE;
        end
        S_ALARM: w_state_nxt = w_tmr_zero ? S_ARMED : S_ALARM;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of timers and outputs, keyed on the state being entered
  always_comb begin
    w_tmr_nxt  = {CNT_W{1'b0}};
    w_blk_nxt  = {BLK_W{1'b0}};
    w_parp_nxt = 1'b0;
    w_nev_nxt  = r_nev;
    w_alr_nxt  = (w_state_nxt == S_ALARM);
    case (w_state_nxt)
      S_PRE: begin
        if (r_state == S_PRE) w_tmr_nxt = w_tmr_zero ? {CNT_W{1'b0}} : r_tmr - CNT_W'(1);
        else                  w_tmr_nxt = CNT_W'(DELAY - 1);
      end
      S_ALARM: begin
        if (r_state == S_ALARM) begin
          w_tmr_nxt = w_tmr_zero ? {CNT_W{1'b0}} : r_tmr - CNT_W'(1);
          if (r_blk == {BLK_W{1'b0}}) begin
            w_blk_nxt  = BLK_W'(BLINK - 1);
            w_parp_nxt = ~r_parp;
          end else begin
            w_blk_nxt  = r_blk - BLK_W'(1);
            w_parp_nxt = r_parp;
          end
        end else begin
          w_tmr_nxt  = CNT_W'(ALARM_LEN - 1);
          w_blk_nxt  = BLK_W'(BLINK - 1);
          w_parp_nxt = 1'b1;
          w_nev_nxt  = (r_nev == 4'd15) ? r_nev : r_nev + 4'd1;
        end
      end
      default: begin
        w_tmr_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  assign sAlr     = r_alr;
  assign sParp    = r_parp;
  assign estado   = r_state;
  assign nEventos = r_nev;

endmodule

// File: tb/tb_alarma_ctrl_temporizada.sv
// Directed self-checking bench for alarma_ctrl_temporizada
// (DELAY=4, ALARM_LEN=16, BLINK=2).
module tb_alarma_ctrl_temporizada;

  logic       clk;
  logic       reset;
  logic       sLuz;
  logic       sPrta;
  logic       sIgn;
  logic       sAlr;
  logic       sParp;
  logic [1:0] estado;
  logic [3:0] nEventos;

  int n_chk;
  int n_err;

  alarma_ctrl_temporizada #(
    .DELAY(4), .ALARM_LEN(16), .BLINK(2), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .sLuz(sLuz), .sPrta(sPrta), .sIgn(sIgn),
    .sAlr(sAlr), .sParp(sParp), .estado(estado), .nEventos(nEventos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    // 1. reset with arbitrary inputs
    reset = 1'b1; sLuz = 1'b1; sPrta = 1'b1; sIgn = 1'b0;
    step(); step();
    chk("rst_estado", estado, 2'b00);
    chk("rst_salr", sAlr, 1'b0);
    chk("rst_sparp", sParp, 1'b0);
    chk("rst_nev", nEventos, 4'd0);
    sLuz = 1'b0; sPrta = 1'b0; sIgn = 1'b1;
    reset = 1'b0;
    step();
    chk("idle_hold", estado, 2'b00);
    sIgn = 1'b0;
    step();
    chk("armed", estado, 2'b01);

    // 2. full event with condition held
    sLuz = 1'b1; sPrta = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pre_state", estado, 2'b10);
      chk("pre_salr", sAlr, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      chk("alarm_state", estado, 2'b11);
      chk("alarm_salr", sAlr, 1'b1);
      chk("alarm_sparp", sParp, ((i / 2) % 2 == 0) ? 1'b1 : 1'b0);
    end
    step();
    chk("post_estado", estado, 2'b01);
    chk("post_salr", sAlr, 1'b0);
    chk("post_sparp", sParp, 1'b0);
    chk("post_nev", nEventos, 4'd1);
    step();
    chk("rearm_pre", estado, 2'b10);

    // 3. abort during grace delay, then a full restart
    step();
    chk("pre2", estado, 2'b10);
    sPrta = 1'b0;
    step();
    chk("abort_estado", estado, 2'b01);
    step();
    chk("abort_salr", sAlr, 1'b0);
    sPrta = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("regrace", estado, 2'b10);
    end
    step();
    chk("regrace_alarm", estado, 2'b11);
    chk("regrace_nev", nEventos, 4'd2);

    // 4. ignition during ALARM cycle 5
    for (int i = 0; i < 4; i++) step();
    chk("alarm_c5", estado, 2'b11);
    sIgn = 1'b1;
    step();
    chk("ign_estado", estado, 2'b00);
    chk("ign_salr", sAlr, 1'b0);
    chk("ign_sparp", sParp, 1'b0);
    chk("ign_nev", nEventos, 4'd2);

    // 5. asynchronous reset in the middle of ALARM
    sIgn = 1'b0;
    step();
    chk("re_armed", estado, 2'b01);
    for (int i = 0; i < 4; i++) step();
    step();
    chk("alarm3", estado, 2'b11);
    chk("alarm3_nev", nEventos, 4'd3);
    step(); step();
    #3;
    reset = 1'b1;
    #1;
    chk("arst_estado", estado, 2'b00);
    chk("arst_salr", sAlr, 1'b0);
    chk("arst_sparp", sParp, 1'b0);
    chk("arst_nev", nEventos, 4'd0);
    step();
    reset = 1'b0;

    // 6. 17 back-to-back events, nEventos saturates at 15
    step();
    chk("sat_armed", estado, 2'b01);
    for (int e = 1; e <= 17; e++) begin
      for (int i = 0; i < 4; i++) step();
      chk("sat_pre_end", estado, 2'b10);
      step();
      chk("sat_alarm", estado, 2'b11);
      chk("sat_nev", nEventos, (e > 15) ? 4'd15 : 4'(e));
      for (int i = 0; i < 15; i++) step();
      chk("sat_alarm_last", sAlr, 1'b1);
      step();
      chk("sat_back_armed", estado, 2'b01);
    end
    chk("sat_final", nEventos, 4'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
